// File: rtl/pipelined_barrel_shifter_if.sv
// pipelined_barrel_shifter_if: operand/result valid-ready bundle; master drives in_*/out_ready, slave drives in_ready/out_*
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 8
);
  localparam int SHW = $clog2(WIDTH);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0] in_shift;
  logic [2:0] in_mode;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic out_zero;
  modport master(
    output in_valid, in_data, in_shift, in_mode, out_ready,
    input in_ready, out_valid, out_data, out_zero
  );
  modport slave(
    input in_valid, in_data, in_shift, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: SHW-stage ROR/ROL/LSR/LSL/ASR log shifter; ports clk, rst_n (sync active-low), bus (slave: in_* operand handshake, out_* result handshake)
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  logic adv;
  logic [SHW-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_in [SHW];
  logic [WIDTH-1:0] d_q [SHW];
  logic [WIDTH-1:0] d_d [SHW];
  logic [SHW-1:0] s_q [SHW];
  logic [SHW-1:0] s_d [SHW];
  logic [2:0] m_q [SHW];
  logic [2:0] m_d [SHW];
  logic z_q, z_d;
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d, input logic [2:0] m,
                                                  input logic en, input int a);
    logic signed [WIDTH-1:0] sa;
    sa = $signed(d) >>> a;
    return !en ? d :
           m == 3'd0 ? (d >> a) | (d << (WIDTH - a)) :
           m == 3'd1 ? (d << a) | (d >> (WIDTH - a)) :
           m == 3'd2 ? d >> a :
           m == 3'd3 ? d << a :
           m == 3'd4 ? sa : d;
  endfunction
  assign adv = !(v_q[SHW-1] && !bus.out_ready);
  assign bus.in_ready = adv;
  assign bus.out_valid = v_q[SHW-1];
  assign bus.out_data = d_q[SHW-1];
  assign bus.out_zero = z_q;
  always_comb begin
    v_d[0] = bus.in_valid;
    d_in[0] = bus.in_data;
    s_d[0] = bus.in_shift;
    m_d[0] = bus.in_mode;
    for (int k = 1; k < SHW; k++) begin
      v_d[k] = v_q[k-1];
      d_in[k] = d_q[k-1];
      s_d[k] = s_q[k-1];
      m_d[k] = m_q[k-1];
    end
    for (int k = 0; k < SHW; k++) d_d[k] = shift_step(d_in[k], m_d[k], s_d[k][k], 1 << k);
    z_d = d_d[SHW-1] == '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      d_q <= '{default: '0};
      s_q <= '{default: '0};
      m_q <= '{default: '0};
      z_q <= 1'b0;
    end else if (adv) begin
      v_q <= v_d;
      d_q <= d_d;
      s_q <= s_d;
      m_q <= m_d;
      z_q <= z_d;
    end
  end
endmodule

// File: doc/pipelined_barrel_shifter.md
# pipelined_barrel_shifter

Parametrised, pipelined successor to the 8-bit combinational rotate-right barrel shifter. It performs rotate-right, rotate-left, logical shift right/left and arithmetic shift right on a WIDTH-bit operand, using one registered log-shifter stage per shift-amount bit. A valid/ready handshake on both sides gives full throughput and lossless backpressure. It sits between an operand source (register file or datapath mux) and a result sink in the lab datapath.

## Interface
- WIDTH, 8, operand width; power of two, ≥ 2.
- SHW, $clog2(WIDTH), shift-amount width and pipeline depth; derived, not overridden.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  input  1  operand/command valid.
- in_ready  output  1  block can accept this cycle.
- in_data  input  WIDTH  operand.
- in_shift  input  SHW  shift amount, 0..WIDTH-1.
- in_mode  input  3  000 ROR, 001 ROL, 010 LSR, 011 LSL, 100 ASR, 101–111 pass-through.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts result.
- out_data  output  WIDTH  shifted result.
- out_zero  output  1  out_data == 0; qualified by out_valid.

## Operation
- Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
- Pipeline of SHW stages, k = 0..SHW-1. Each stage register holds valid, data, remaining shift bits, and mode. Stage k shifts by 2^k in the mode's direction when shift bit k is 1, otherwise passes data unchanged.
- Fill rules per stage:
  - ROR/ROL: vacated bits are taken from the bits shifted out (wrap-around).
  - LSR/LSL: vacated bits are 0.
  - ASR: vacated bits are copies of data[WIDTH-1]. Sign is preserved stage to stage, so the result equals a signed shift by the full amount.
- Pass-through modes (101–111): data is unchanged regardless of in_shift.
- Shift of 0 in any mode: out_data = in_data.
- out_zero is registered in the final stage together with out_data.
- Global advance enable: adv = !(out_valid && !out_ready).
  - When adv = 1, every stage loads from its predecessor and stage 0 loads the input transfer. A stage with no incoming transfer loads valid = 0 (a bubble).
  - When adv = 0, all stages hold.
- in_ready = adv; this is a combinational path from out_ready and out_valid.
- Results leave strictly in acceptance order. No op is dropped or duplicated under any backpressure pattern.
- Reset (rst_n = 0 at a clock edge), including mid-operation:
  - all stage valid bits, out_valid and out_zero go to 0;
  - all data, shift and mode registers go to 0;
  - in-flight ops are discarded;
  - in_ready = 1 from the first cycle after reset is released.

## Timing
- Latency is SHW cycles from input transfer to out_valid, with no stall (3 cycles for WIDTH = 8).
- Throughput is one op per cycle when out_ready is held high.
- A stall cycle (out_valid && !out_ready) freezes the whole pipeline and adds exactly one cycle to every in-flight op.
- Simultaneous output transfer and input transfer in the same cycle is legal and keeps full throughput.
- out_data and out_zero are stable while out_valid && !out_ready.

## Test plan
- Mode sweep, WIDTH = 8, in_data = 0xB4, in_shift = 3, out_ready = 1. Expected out_data 3 cycles after each accept:
  - ROR → 0x96
  - ROL → 0xA5
  - LSR → 0x16
  - LSL → 0xA0
  - ASR → 0xF6
  - mode 101 → 0xB4
  - all with out_zero = 0.
- Boundaries:
  - in_shift = 0, any mode → 0xB4.
  - ASR 0x80 by 7 → 0xFF.
  - LSR 0x80 by 7 → 0x01.
  - LSL 0x80 by 1 → 0x00 with out_zero = 1.
  - ROR 0x01 by 7 → 0x02.
- Streaming: 8 back-to-back ops, out_ready = 1 → 8 consecutive out_valid cycles, in order, with in_ready held at 1.
- Backpressure: stream ops 0x01..0x05 (ROL by 1), drop out_ready for 2 cycles after the first result. Expected:
  - in_ready = 0 during the stall;
  - out_data held at 0x02;
  - results then continue 0x02, 0x04, 0x06, 0x08, 0x0A with no loss.
- Reset mid-stream: assert rst_n = 0 for 1 cycle with 2 ops in flight. Expected: out_valid = 0 the next cycle, no stale result appears afterwards, in_ready = 1 after release.
- Parameter check: WIDTH = 16, ROR 0x1234 by 4 → 0x4123 after 4 cycles; WIDTH = 32, ASR 0x80000000 by 31 → 0xFFFFFFFF after 5 cycles.
